// File: rtl/data_ram_wait.sv
// rtl/data_ram_wait.sv - data-memory responder with programmable wait states and one-cycle ready pulse
module data_ram_wait #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [3:0]             sel_q;
  logic [31:0]            wdata_q;
  logic [31:0]            data_q, data_d;
  logic                   ready_q, ready_d;

  logic [31:0]            mem [DEPTH];

  logic                   in_idle;
  logic                   req_we;
  logic [ADDR_BITS-1:0]   req_idx;
  logic [3:0]             req_sel;
  logic [31:0]            req_wdata;
  logic                   unused_addr;

  assign unused_addr = ^{addr_i[31:ADDR_BITS+2], addr_i[1:0]};

  // With zero wait states the access commits on the acceptance edge, so use live inputs in IDLE.
  assign in_idle   = (state_q == S_IDLE);
  assign req_we    = in_idle ? we_i : we_q;
  assign req_idx   = in_idle ? addr_i[ADDR_BITS+1:2] : idx_q;
  assign req_sel   = in_idle ? sel_i : sel_q;
  assign req_wdata = in_idle ? data_i : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      data_d  = req_we ? 32'd0 : mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      if (in_idle && ce_i) begin
        we_q    <= we_i;
        idx_q   <= addr_i[ADDR_BITS+1:2];
        sel_q   <= sel_i;
        wdata_q <= data_i;
      end
    end
  end

  // Array is never cleared; a reset on the commit edge discards the pending write.
  always_ff @(posedge clk) begin
    if (!rst && state_d == S_RESP && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;

endmodule
